// File: rtl/pdl_burst_sequencer.sv
// pdl_burst_sequencer: configures and triggers a bank of pulse-delay-line channels.
// Per-channel delay/width values are staged in shadow registers and copied to
// the active outputs at the start of each burst. The burst then fires BURST
// trigger pulses, TRIG_W clocks high, spaced per_eff clocks apart.
module pdl_burst_sequencer #(
    parameter int N       = 32,
    parameter int OUT_NUM = 8,
    parameter int AW      = 3,
    parameter int TRIG_W  = 2,
    parameter int MIN_PER = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [N-1:0]         cfg_data,
    input  logic [OUT_NUM-1:0]   chan_en,
    input  logic [N-1:0]         period,
    input  logic [15:0]          burst,
    input  logic                 start,
    input  logic                 abort,
    output logic [OUT_NUM*N-1:0] dl_out,
    output logic [OUT_NUM*N-1:0] wb_out,
    output logic [OUT_NUM-1:0]   trig_out,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [15:0]          pulse_idx
);

    typedef enum logic [2:0] {IDLE, ARM, FIRE, GAP, FIN} state_t;

    state_t state;
    state_t state_nx;

    logic [N-1:0]       dl_shadow [OUT_NUM];
    logic [N-1:0]       wb_shadow [OUT_NUM];

    logic [OUT_NUM-1:0] mask;
    logic [N-1:0]       per_eff;
    logic [15:0]        burst_len;
    logic [N-1:0]       cnt;
    logic [N-1:0]       cnt_nx;
    logic [N-1:0]       per_in;

    logic               launch;
    logic               copy;
    logic               pidx_step;
    logic               kill;
    logic               done_nx;

    // Very short periods are stretched so the trigger high time always fits.
    assign per_in = (period < N'(MIN_PER)) ? N'(MIN_PER) : period;

    // Next-state and control decode; abort overrides everything except FIN.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        launch    = 1'b0;
        copy      = 1'b0;
        pidx_step = 1'b0;
        kill      = 1'b0;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    launch  = 1'b1;
                    // An empty burst completes immediately with no trigger.
                    state_nx = (burst == '0) ? FIN : ARM;
                    done_nx  = (burst == '0);
                end
            end
            ARM: begin
                copy      = 1'b1;
                cnt_nx    = '0;
                pidx_step = 1'b1;
                state_nx  = FIRE;
            end
            FIRE: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == N'(TRIG_W - 1)) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (cnt == per_eff - 1'b1) begin
                    cnt_nx = '0;
                    if (pulse_idx < burst_len) begin
                        pidx_step = 1'b1;
                        state_nx  = FIRE;
                    end else begin
                        state_nx = FIN;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            FIN: begin
                // done is registered one clock after FIN for a real burst; the
                // empty-burst case already pulsed it on the way in.
                state_nx = IDLE;
                done_nx  = (pulse_idx != '0);
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (abort && (state == ARM || state == FIRE || state == GAP)) begin
            state_nx  = IDLE;
            copy      = 1'b0;
            pidx_step = 1'b0;
            kill      = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Burst parameters, period counter, pulse count and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask      <= '0;
            per_eff   <= '0;
            burst_len <= '0;
            cnt       <= '0;
            pulse_idx <= '0;
            trig_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            if (launch) begin
                mask      <= chan_en;
                per_eff   <= per_in;
                burst_len <= burst;
                pulse_idx <= '0;
            end else if (pidx_step) begin
                pulse_idx <= pulse_idx + 16'd1;
            end
            trig_out <= (state_nx == FIRE) ? mask : '0;
            busy     <= (state_nx != IDLE);
            done     <= done_nx;
            aborted  <= kill;
        end
    end

    // Shadow register writes; addresses beyond the channel count match no entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < OUT_NUM; k++) begin
                dl_shadow[k] <= '0;
                wb_shadow[k] <= '0;
            end
        end else if (cfg_we) begin
            for (int k = 0; k < OUT_NUM; k++) begin
                if (cfg_addr == AW'(k)) begin
                    if (cfg_sel) begin
                        wb_shadow[k] <= cfg_data;
                    end else begin
                        dl_shadow[k] <= cfg_data;
                    end
                end
            end
        end
    end

    // Active delay/width registers only follow the shadows while arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_out <= '0;
            wb_out <= '0;
        end else if (copy) begin
            for (int k = 0; k < OUT_NUM; k++) begin
                dl_out[k*N +: N] <= dl_shadow[k];
                wb_out[k*N +: N] <= wb_shadow[k];
            end
        end
    end

endmodule

// File: tb/tb_pdl_burst_sequencer.sv
// Testbench for pdl_burst_sequencer: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a time-based model.
module tb_pdl_burst_sequencer;

    localparam int N       = 32;
    localparam int OUT_NUM = 8;
    localparam int AW      = 4;
    localparam int W       = OUT_NUM * N;

    logic               clk;
    logic               reset;
    logic               cfg_we;
    logic               cfg_sel;
    logic [AW-1:0]      cfg_addr;
    logic [N-1:0]       cfg_data;
    logic [OUT_NUM-1:0] chan_en;
    logic [N-1:0]       period;
    logic [15:0]        burst;
    logic               start;
    logic               abort;
    logic [W-1:0]       dl_out;
    logic [W-1:0]       wb_out;
    logic [OUT_NUM-1:0] trig_out;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [15:0]        pulse_idx;

    pdl_burst_sequencer #(
        .N(N), .OUT_NUM(OUT_NUM), .AW(AW), .TRIG_W(2), .MIN_PER(4)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .chan_en(chan_en),
        .period(period), .burst(burst), .start(start), .abort(abort),
        .dl_out(dl_out), .wb_out(wb_out), .trig_out(trig_out), .busy(busy),
        .done(done), .aborted(aborted), .pulse_idx(pulse_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int off      = 0;
    bit chk_en   = 0;

    // Model expectations
    logic [W-1:0]       exp_dl    = '0;
    logic [W-1:0]       exp_wb    = '0;
    logic [OUT_NUM-1:0] exp_trig  = '0;
    logic               exp_busy  = 1'b0;
    logic               exp_done  = 1'b0;
    logic               exp_ab    = 1'b0;
    logic [15:0]        exp_pidx  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a burst is described by its start edge, length B and
    // spacing P; every output is a function of the clocks elapsed since start.
    initial begin : model
        logic [N-1:0] m_dl [OUT_NUM];
        logic [N-1:0] m_wb [OUT_NUM];
        bit           act;
        longint       e, b, p, q;
        logic [OUT_NUM-1:0] m_mask;
        act = 0; e = 0; b = 0; p = 4; m_mask = '0;
        for (int k = 0; k < OUT_NUM; k++) begin
            m_dl[k] = '0;
            m_wb[k] = '0;
        end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                act = 0;
                for (int k = 0; k < OUT_NUM; k++) begin
                    m_dl[k] = '0;
                    m_wb[k] = '0;
                end
                exp_dl = '0; exp_wb = '0; exp_trig = '0; exp_busy = 0;
                exp_done = 0; exp_ab = 0; exp_pidx = '0;
            end else begin
                exp_done = 0;
                exp_ab   = 0;
                if (act) begin
                    e++;
                    if (abort && b > 0 && e <= 1 + b * p) begin
                        act = 0; exp_busy = 0; exp_trig = '0; exp_ab = 1;
                    end else if (b == 0) begin
                        act = 0; exp_busy = 0;
                    end else if (e == 2 + b * p) begin
                        act = 0; exp_busy = 0; exp_done = 1; exp_trig = '0;
                    end else begin
                        if (e == 1) begin
                            for (int k = 0; k < OUT_NUM; k++) begin
                                exp_dl[k*N +: N] = m_dl[k];
                                exp_wb[k*N +: N] = m_wb[k];
                            end
                        end
                        exp_trig = (e <= b * p && ((e - 1) % p) < 2) ? m_mask : '0;
                        q = (e - 1) / p + 1;
                        if (q > b) q = b;
                        exp_pidx = 16'(q);
                    end
                end else if (start && !abort) begin
                    act = 1; e = 0; b = longint'(burst);
                    p = (period < 4) ? 4 : longint'(period);
                    m_mask = chan_en; exp_pidx = '0; exp_busy = 1; exp_trig = '0;
                    exp_done = (burst == 0);
                end
                if (cfg_we && cfg_addr < 4'(OUT_NUM)) begin
                    if (cfg_sel) m_wb[cfg_addr[2:0]] = cfg_data;
                    else         m_dl[cfg_addr[2:0]] = cfg_data;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_trig", trig_out, exp_trig);
                check("cyc_busy", busy, exp_busy);
                check("cyc_done", done, exp_done);
                check("cyc_aborted", aborted, exp_ab);
                check("cyc_pulse_idx", pulse_idx, exp_pidx);
                check("cyc_dl_out", dl_out, exp_dl);
                check("cyc_wb_out", wb_out, exp_wb);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
        off++;
    endtask

    task automatic go(input int k);
        while (off < k) step();
    endtask

    task automatic wr(input bit sel, input int a, input int d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = AW'(a); cfg_data = N'(d);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic launch(input logic [OUT_NUM-1:0] m, input int p, input int b);
        chan_en = m; period = N'(p); burst = 16'(b); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        off = 0;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while (busy && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    initial begin : stim
        cfg_we = 0; cfg_sel = 0; cfg_addr = '0; cfg_data = '0; chan_en = '0;
        period = '0; burst = '0; start = 0; abort = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dl", dl_out, 0);
        check("rst_wb", wb_out, 0);
        check("rst_trig", trig_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_pidx", pulse_idx, 0);
        reset = 1'b1;
        chk_en = 1;
        step(); step();

        // Single burst: ch0 delay 10, width 5, period 20, three pulses
        wr(0, 0, 10); wr(1, 0, 5);
        launch(8'h01, 20, 3);
        check("t2_busy0", busy, 1);
        check("t2_trig0", trig_out, 0);
        go(1);
        check("t2_trig1", trig_out, 8'h01);
        check("t2_pidx1", pulse_idx, 1);
        check("t2_dl_ch0", dl_out[N-1:0], 10);
        check("t2_wb_ch0", wb_out[N-1:0], 5);
        go(2);  check("t2_trig2", trig_out, 8'h01);
        go(3);  check("t2_trig3", trig_out, 0);
        go(9);  wr(0, 0, 99);
        go(20); check("t2_trig20", trig_out, 0);
        go(21); check("t2_trig21", trig_out, 8'h01);
        check("t2_pidx21", pulse_idx, 2);
        go(30); check("t3_dl_hold", dl_out[N-1:0], 10);
        go(41); check("t2_trig41", trig_out, 8'h01);
        check("t2_pidx41", pulse_idx, 3);
        go(61); check("t2_busy61", busy, 1);
        check("t2_done61", done, 0);
        go(62); check("t2_done62", done, 1);
        check("t2_busy62", busy, 0);
        check("t2_pidx62", pulse_idx, 3);
        go(63); check("t2_done63", done, 0);

        // The write made during the previous burst appears on the next one
        launch(8'h01, 4, 1);
        go(1);  check("t3_dl_new", dl_out[N-1:0], 99);
        wait_idle(20);

        // Empty burst
        launch(8'h01, 20, 0);
        check("t5_b0_done", done, 1);
        check("t5_b0_busy", busy, 1);
        check("t5_b0_trig", trig_out, 0);
        go(1);  check("t5_b0_done_off", done, 0);
        check("t5_b0_idle", busy, 0);

        // Period below the minimum stretches to 4
        launch(8'h01, 1, 3);
        go(1);  check("t5_p1_trig1", trig_out, 8'h01);
        go(4);  check("t5_p1_trig4", trig_out, 0);
        go(5);  check("t5_p1_trig5", trig_out, 8'h01);
        go(9);  check("t5_p1_trig9", trig_out, 8'h01);
        go(13); check("t5_p1_busy13", busy, 1);
        go(14); check("t5_p1_done14", done, 1);
        check("t5_p1_pidx", pulse_idx, 3);

        // Out-of-range addresses leave the shadows untouched
        wr(0, 8, 'hDEAD); wr(1, 8, 'hBEEF); wr(0, 15, 1);
        launch(8'h01, 4, 1);
        go(1);
        check("t5_addr8_dl", dl_out, W'(99));
        check("t5_addr8_wb", wb_out, W'(5));
        wait_idle(20);

        // start together with abort in IDLE does nothing
        chan_en = 8'hFF; period = 4; burst = 2; start = 1; abort = 1;
        step();
        start = 0; abort = 0;
        check("t6_sa_busy", busy, 0);
        check("t6_sa_aborted", aborted, 0);
        step();
        check("t6_sa_trig", trig_out, 0);

        // Partial enable mask, and a start while busy that must be ignored
        launch(8'hA5, 8, 4);
        go(1);  check("t6_mask", trig_out, 8'hA5);
        go(4);
        chan_en = 8'hFF; burst = 1; period = 4; start = 1;
        step();
        start = 0;
        go(9);  check("t6_mask2", trig_out, 8'hA5);
        go(33); check("t6_busy33", busy, 1);
        go(34); check("t6_done34", done, 1);
        check("t6_pidx", pulse_idx, 4);

        // Abort in the fourth gap
        launch(8'hFF, 50, 10);
        go(151); check("t4_pidx151", pulse_idx, 4);
        check("t4_trig151", trig_out, 8'hFF);
        go(159);
        abort = 1;
        step();
        abort = 0;
        check("t4_aborted", aborted, 1);
        check("t4_busy", busy, 0);
        check("t4_trig", trig_out, 0);
        check("t4_done", done, 0);
        check("t4_pidx", pulse_idx, 4);
        step();
        check("t4_aborted_off", aborted, 0);
        go(215);
        check("t4_trig_after", trig_out, 0);
        check("t4_dl_kept", dl_out, W'(99));

        // Asynchronous reset in the middle of a burst
        wr(0, 3, 7); wr(1, 3, 9);
        launch(8'hFF, 10, 5);
        go(12);
        check("t1_dl_ch3", dl_out[3*N +: N], 7);
        #2 reset = 1'b0;
        #1;
        check("t1_rst_dl", dl_out, 0);
        check("t1_rst_wb", wb_out, 0);
        check("t1_rst_trig", trig_out, 0);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_pidx", pulse_idx, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        launch(8'hFF, 4, 1);
        go(1);
        check("t1_shadow_dl", dl_out, 0);
        check("t1_shadow_wb", wb_out, 0);
        wait_idle(20);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_sel  = 1'($urandom_range(0, 1));
            cfg_addr = AW'($urandom_range(0, 15));
            cfg_data = N'($urandom);
            chan_en  = OUT_NUM'($urandom);
            period   = N'($urandom_range(0, 12));
            burst    = 16'($urandom_range(0, 4));
            start    = ($urandom_range(0, 7) == 0);
            abort    = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        cfg_we = 0; start = 0; abort = 0;
        wait_idle(1000);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
